// File: rtl/gpio_periph_if.sv
// CPU-side register bus for gpio_periph: address, write data, write strobe, read data.
// Latency: none (wires only); rdata is registered inside the slave.
// Backpressure: none; the bus is single-master and every access completes in one cycle.
//
// Signals:
//   addr  [31:0] byte address from the CPU (bits [1:0] ignored by the slave)
//   wdata [31:0] write data from the CPU
//   we           write strobe, one write per clk edge while high
//   rdata [31:0] read data, valid one cycle after addr is presented
interface gpio_periph_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata
  );
endinterface

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO: pad outputs/enables, synchronized inputs, rising-edge level irq.
// Latency: writes visible on pads/irq the cycle after the write edge; reads return 1 cycle later.
// Backpressure: none; every bus access completes in one cycle, no stall signal exists.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   bus (slave)     CPU register bus: addr, wdata, we in; rdata out (registered)
//   gpio_in         asynchronous pad inputs, double-flopped before use
//   gpio_out        pad output values (DATA_OUT)
//   gpio_oe         pad output enables (DIR, 1 = drive)
//   irq             level interrupt, |(IRQ_STAT & IRQ_EN)
//
// Register map (offset within the window, addr[1:0] ignored):
//   0x00 DATA_OUT RW | 0x04 DIR RW | 0x08 DATA_IN RO | 0x0C IRQ_EN RW | 0x10 IRQ_STAT W1C
module gpio_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          WIN_BITS  = 12,
  parameter int          WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  gpio_periph_if.slave     bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [WIN_BITS-1:0] OFF_DOUT = WIN_BITS'(32'h00);
  localparam logic [WIN_BITS-1:0] OFF_DIR  = WIN_BITS'(32'h04);
  localparam logic [WIN_BITS-1:0] OFF_DIN  = WIN_BITS'(32'h08);
  localparam logic [WIN_BITS-1:0] OFF_IEN  = WIN_BITS'(32'h0C);
  localparam logic [WIN_BITS-1:0] OFF_STAT = WIN_BITS'(32'h10);
  localparam logic [WIN_BITS-1:0] WORD_MSK = ~WIN_BITS'(32'h3);

  // Architectural state
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [WIDTH-1:0] dir_q,   dir_d;
  logic [WIDTH-1:0] ien_q,   ien_d;
  logic [WIDTH-1:0] stat_q,  stat_d;
  // Input synchronizer and edge-detect history
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q,  prev_d;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  // Decode
  logic                sel;
  logic [WIN_BITS-1:0] off;
  logic                wr_en;
  logic                arm;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    w1c_mask;
  logic [WIDTH-1:0]    wr_bits;
  logic [WIDTH-1:0]    rd_bits;

  // Upper write-data bits beyond WIDTH are architecturally discarded.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  assign sel     = (bus.addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign off     = bus.addr[WIN_BITS-1:0] & WORD_MSK;
  assign wr_en   = bus.we & sel;
  assign wr_bits = bus.wdata[WIDTH-1:0];

  // Edges are suppressed for the first three cycles after reset so a pad
  // already high at reset release is not mistaken for a rising edge.
  assign arm  = (arm_cnt_q == 2'd3);
  assign rise = sync2_q & ~prev_q & {WIDTH{arm}};

  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    ien_d     = ien_q;
    w1c_mask  = '0;
    sync1_d   = gpio_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + 2'd1;

    if (wr_en) begin
      case (off)
        OFF_DOUT: dout_d   = wr_bits;
        OFF_DIR:  dir_d    = wr_bits;
        OFF_IEN:  ien_d    = wr_bits;
        OFF_STAT: w1c_mask = wr_bits;
        default:  ;  // DATA_IN and unmapped offsets ignore writes
      endcase
    end

    // A new edge on the same cycle as a clear keeps the bit set.
    stat_d = (stat_q & ~w1c_mask) | rise;
  end

  // Read mux sees pre-write register values, so a read of a register being
  // written in the same cycle returns the old contents.
  always_comb begin
    rd_bits = '0;
    if (sel) begin
      case (off)
        OFF_DOUT: rd_bits = dout_q;
        OFF_DIR:  rd_bits = dir_q;
        OFF_DIN:  rd_bits = sync2_q;
        OFF_IEN:  rd_bits = ien_q;
        OFF_STAT: rd_bits = stat_q;
        default:  rd_bits = '0;
      endcase
    end
    rdata_d = '0;
    rdata_d[WIDTH-1:0] = rd_bits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      dir_q     <= '0;
      ien_q     <= '0;
      stat_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      ien_q     <= ien_d;
      stat_q    <= stat_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign gpio_out  = dout_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(stat_q & ien_q);

endmodule

// File: tb/tb_gpio_periph.sv
// Directed bench for gpio_periph: reset, register access, input sync, edge irq, W1C, decode.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
module tb_gpio_periph;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;
  logic [31:0] rd;

  int vec_cnt = 0;
  int err_cnt = 0;

  gpio_periph_if bif ();

  gpio_periph #(
    .BASE_ADDR(BASE),
    .WIN_BITS (12),
    .WIDTH    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bif.addr  = a;
    bif.wdata = d;
    bif.we    = 1'b1;
    tick();
    bif.we    = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bif.addr = a;
    bif.we   = 1'b0;
    tick();
    d = bif.rdata;
  endtask

  initial begin
    rst       = 1'b1;
    gpio_in   = 8'h81;
    bif.addr  = '0;
    bif.wdata = '0;
    bif.we    = 1'b0;
    tick();
    tick();

    // Write during reset must be dropped
    bus_wr(BASE, 32'hFF);
    check_vec("rst_gpio_out", 32'(gpio_out), 32'h0);
    check_vec("rst_gpio_oe",  32'(gpio_oe),  32'h0);
    check_vec("rst_irq",      32'(irq),      32'h0);
    check_vec("rst_rdata",    bif.rdata,     32'h0);

    // Pads held high across reset release: no spurious edges
    rst = 1'b0;
    repeat (10) tick();
    check_vec("arm_irq", 32'(irq), 32'h0);
    bus_rd(BASE + 32'h10, rd);
    check_vec("arm_stat", rd, 32'h0);
    bus_rd(BASE + 32'h08, rd);
    check_vec("arm_din", rd, 32'h81);

    // CPU write then read of DATA_OUT
    bif.addr  = BASE;
    bif.wdata = 32'hA5;
    bif.we    = 1'b1;
    tick();
    bif.we    = 1'b0;
    check_vec("dout_old_rdata", bif.rdata, 32'h0);
    check_vec("dout_pad", 32'(gpio_out), 32'hA5);
    tick();
    check_vec("dout_rdata", bif.rdata, 32'hA5);

    // DIR and upper-bit masking
    bus_wr(BASE + 32'h04, 32'h0F);
    check_vec("dir_oe", 32'(gpio_oe), 32'h0F);
    bus_rd(BASE + 32'h04, rd);
    check_vec("dir_rd", rd, 32'h0000_000F);
    bus_wr(BASE + 32'h04, 32'hFFFF_FF00);
    check_vec("dir_hi_oe", 32'(gpio_oe), 32'h00);
    bus_rd(BASE + 32'h04, rd);
    check_vec("dir_hi_rd", rd, 32'h0);
    bus_wr(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_rd(BASE + 32'h04, rd);
    check_vec("dir_all_rd", rd, 32'h0000_00FF);
    bus_wr(BASE + 32'h04, 32'h3C);

    // DATA_IN is read-only
    bus_wr(BASE + 32'h08, 32'h0);
    bus_rd(BASE + 32'h08, rd);
    check_vec("din_ro", rd, 32'h81);

    // Rising edge on bit0 with IRQ_EN[0]
    gpio_in = 8'h80;
    repeat (4) tick();
    bus_wr(BASE + 32'h10, 32'hFF);
    bus_rd(BASE + 32'h10, rd);
    check_vec("stat_clr0", rd, 32'h0);
    bus_wr(BASE + 32'h0C, 32'h01);
    bus_rd(BASE + 32'h0C, rd);
    check_vec("ien_rd", rd, 32'h01);
    gpio_in = 8'h81;
    tick();
    tick();
    check_vec("edge_irq_early", 32'(irq), 32'h0);
    bus_rd(BASE + 32'h08, rd);
    check_vec("edge_din", rd, 32'h81);
    check_vec("edge_irq", 32'(irq), 32'h1);
    bus_rd(BASE + 32'h10, rd);
    check_vec("edge_stat", rd, 32'h01);
    bus_wr(BASE + 32'h10, 32'h01);
    check_vec("w1c_irq", 32'(irq), 32'h0);
    bus_rd(BASE + 32'h10, rd);
    check_vec("w1c_stat", rd, 32'h0);

    // Edge on disabled bit7: recorded but no irq
    gpio_in = 8'h01;
    repeat (4) tick();
    gpio_in = 8'h81;
    repeat (4) tick();
    check_vec("dis_irq", 32'(irq), 32'h0);
    bus_rd(BASE + 32'h10, rd);
    check_vec("dis_stat", rd, 32'h80);
    bus_wr(BASE + 32'h10, 32'h80);
    bus_rd(BASE + 32'h10, rd);
    check_vec("dis_clr", rd, 32'h0);

    // W1C on the same edge a new rise is detected: set wins
    gpio_in = 8'h80;
    repeat (4) tick();
    gpio_in = 8'h81;
    tick();
    tick();
    bus_wr(BASE + 32'h10, 32'h01);
    check_vec("race_irq", 32'(irq), 32'h1);
    bus_rd(BASE + 32'h10, rd);
    check_vec("race_stat", rd, 32'h01);
    bus_wr(BASE + 32'h10, 32'hFF);
    bus_rd(BASE + 32'h10, rd);
    check_vec("race_clr", rd, 32'h0);

    // Decode: unselected, unmapped, just past window
    bus_wr(32'h0300_0000, 32'h55);
    bus_rd(32'h0300_0000, rd);
    check_vec("unsel_rd", rd, 32'h0);
    bus_wr(BASE + 32'h20, 32'h55);
    bus_rd(BASE + 32'h20, rd);
    check_vec("unmap_rd", rd, 32'h0);
    bus_wr(BASE + 32'h1000, 32'h55);
    bus_rd(BASE + 32'h1000, rd);
    check_vec("pastwin_rd", rd, 32'h0);
    bus_wr(32'h0300_0004, 32'h55);
    bus_wr(32'h0300_000C, 32'h55);
    check_vec("keep_out", 32'(gpio_out), 32'hA5);
    check_vec("keep_oe",  32'(gpio_oe),  32'h3C);
    bus_rd(BASE + 32'h03, rd);
    check_vec("lowbits_dout", rd, 32'hA5);
    bus_rd(BASE + 32'h0F, rd);
    check_vec("lowbits_ien", rd, 32'h01);
    bus_rd(BASE + 32'h10, rd);
    check_vec("keep_stat", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/gpio_periph.md
Name: gpio_periph

Overview:
Memory-mapped GPIO peripheral on the CPU's single-master bus, sitting directly downstream of the CPU core. It decodes the CPU's addr/wdata/we and returns rdata. It also drives output pads, synchronizes input pads and raises a level interrupt on enabled rising edges. Its base address is 0x0200_0000, which is the CPU's GPIO target.

Parameters:
BASE_ADDR, 32'h0200_0000, base of the register window.
WIN_BITS, 12, log2 window size in bytes; select = (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]).
WIDTH, 8, number of GPIO pins (1..32).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
addr  input  32  byte address from CPU; addr[1:0] ignored.
wdata  input  32  write data from CPU.
we  input  1  write strobe; a write occurs on every clk edge where we=1 and the window is selected.
rdata  output  32  registered read data for the address presented in the previous cycle.
gpio_in  input  WIDTH  asynchronous pad inputs.
gpio_out  output  WIDTH  pad output values (= DATA_OUT).
gpio_oe  output  WIDTH  pad output enables (= DIR; 1 = drive).
irq  output  1  level interrupt = |(IRQ_STAT & IRQ_EN).

Behaviour:
- Reset (rst=1 at a clk edge): DATA_OUT, DIR, IRQ_EN, IRQ_STAT, sync1, sync2, prev and arm_cnt all clear to 0. rdata=0, gpio_out=0, gpio_oe=0, irq=0. Reset overrides any same-cycle write.
- Register map (offset = addr[WIN_BITS-1:0] with bits [1:0] masked):
  - 0x00 DATA_OUT, RW.
  - 0x04 DIR, RW.
  - 0x08 DATA_IN, RO; returns sync2.
  - 0x0C IRQ_EN, RW.
  - 0x10 IRQ_STAT, W1C.
- Only bits [WIDTH-1:0] are stored or written. rdata bits [31:WIDTH] always read 0.
- Unmapped offsets inside the window read 0; writes to them are ignored.
- Unselected address: writes ignored, rdata loads 0.
- Write timing: the register updates at the edge where we=1. gpio_out, gpio_oe and irq reflect the new value in the following cycle (no extra stage).
- Read timing: every edge, rdata <= mux(addr), taken from register values before any same-edge write. Read latency is 1 cycle. Reads have no side effects.
- Write to DATA_IN: ignored.
- Input path: sync1 <= gpio_in; sync2 <= sync1; prev <= sync2. A pad change is visible in DATA_IN 2 edges after capture.
- Edge detect: rise = sync2 & ~prev & {WIDTH{arm}}.
- Arm counter: arm_cnt is 2 bits and increments each edge after reset until it saturates at 3. arm = (arm_cnt == 3). This masks spurious edges from pads held high across reset release.
- IRQ_STAT per bit: next = (stat & ~(w1c_mask)) | rise, where w1c_mask = wdata when writing offset 0x10, else 0.
  - Set wins over a same-cycle clear.
  - IRQ_STAT records edges regardless of IRQ_EN. IRQ_EN only gates irq.
- No state machine beyond the arm counter. All logic lives in one always block on posedge clk plus combinational decode/mux.

Test Plan:
- CPU pattern: we=1, addr=0x0200_0000, wdata=0xA5 for one cycle, then we=0 with the same addr. Required: gpio_out=0xA5 the cycle after the write edge; rdata=0x00 after the write edge; rdata=0xA5 one edge later.
- Write DIR=0x0F at 0x0200_0004, then read it back. Required: gpio_oe=0x0F, rdata=0x0000000F. Write 0xFFFF_FF00 to DIR: gpio_oe=0x00 and upper rdata bits stay 0.
- Hold gpio_in=0x81 high through reset and release reset. Required: IRQ_STAT=0 and irq=0 after 10 cycles, and DATA_IN reads 0x81.
- With IRQ_EN=0x01 and armed, toggle gpio_in[0] 0→1. Required: IRQ_STAT bit0=1 three edges after capture and irq=1. Write 0x01 to 0x0200_0010: IRQ_STAT=0 and irq=0 next cycle.
- Issue a W1C of bit0 on the same edge a new rise on bit0 is detected. Required: IRQ_STAT bit0 stays 1.
- Write 0x55 to 0x0300_0000 and to offset 0x20. Required: all registers are unchanged and reads of those addresses return 0x00000000.
